alu_control: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_control_decode.sv | 51 +++++
 rtl/alu_control.sv | 45 ++++
 tb/tb_alu_control.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, main-control class codes and supported
// R-type function codes for the MIPS execute-stage ALU control.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_NOR     = 4'b1100,
    ALU_INVALID = 4'b1111
  } alu_oper_e;

  localparam logic [1:0] ALUOP_LWSW  = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;
  localparam logic [3:0] FUNCT_NOR = 4'b0111;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational mapping of main-control ALU class and R-type funct field
// onto the ALU operation select, flagging unsupported function codes.
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_field_i,
  output alu_oper_e  operation_o,
  output logic       illegal_o
);

  // Only funct[3:0] distinguishes the supported R-type operations.
  logic unused_funct_hi;
  assign unused_funct_hi = ^funct_field_i[5:4];

  always_comb begin
    operation_o = ALU_INVALID;
    illegal_o   = 1'b1;
    case (alu_op_i)
      ALUOP_LWSW: begin
        operation_o = ALU_ADD;
        illegal_o   = 1'b0;
      end
      ALUOP_BEQ, 2'b11: begin
        operation_o = ALU_SUB;
        illegal_o   = 1'b0;
      end
      ALUOP_RTYPE: begin
        // Unknown or X funct bits match no item and fall to INVALID.
        illegal_o = 1'b0;
        case (funct_field_i[3:0])
          FUNCT_ADD: operation_o = ALU_ADD;
          FUNCT_SUB: operation_o = ALU_SUB;
          FUNCT_AND: operation_o = ALU_AND;
          FUNCT_OR:  operation_o = ALU_OR;
          FUNCT_SLT: operation_o = ALU_SLT;
          FUNCT_NOR: operation_o = ALU_NOR;
          default: begin
            operation_o = ALU_INVALID;
            illegal_o   = 1'b1;
          end
        endcase
      end
      default: begin
        operation_o = ALU_INVALID;
        illegal_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control for the MIPS execute stage: combinational decode followed by
// one register stage; result holds while valid_i is low.
module alu_control
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       valid_i,
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_field_i,
  output logic [3:0] operation_o,
  output logic       valid_o,
  output logic       illegal_o
);

  alu_oper_e operation_d, operation_q;
  logic      illegal_d, illegal_q;
  logic      valid_q;

  alu_control_decode u_decode (
    .alu_op_i      (alu_op_i),
    .funct_field_i (funct_field_i),
    .operation_o   (operation_d),
    .illegal_o     (illegal_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      operation_q <= ALU_ADD;
      illegal_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        operation_q <= operation_d;
        illegal_q   <= illegal_d;
      end
    end
  end

  assign operation_o = operation_q;
  assign illegal_o   = illegal_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for alu_control; compares {valid, illegal,
// operation} against hand-computed values one cycle after each input.
module tb_alu_control;

  logic       clk_i;
  logic       rst_n_i;
  logic       valid_i;
  logic [1:0] alu_op_i;
  logic [5:0] funct_field_i;
  logic [3:0] operation_o;
  logic       valid_o;
  logic       illegal_o;

  int unsigned n_cmp;
  int unsigned n_bad;

  alu_control dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .valid_i       (valid_i),
    .alu_op_i      (alu_op_i),
    .funct_field_i (funct_field_i),
    .operation_o   (operation_o),
    .valid_o       (valid_o),
    .illegal_o     (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // obs/exp packed as {valid, illegal, operation[3:0]}
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%b ill=%b op=%b, want v=%b ill=%b op=%b",
               tag, obs[5], obs[4], obs[3:0], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] eop, input logic eill);
    @(negedge clk_i);
    valid_i       = 1'b1;
    alu_op_i      = op;
    funct_field_i = fn;
    @(posedge clk_i);
    #1;
    chk(tag, {valid_o, illegal_o, operation_o}, {1'b1, eill, eop});
  endtask

  logic [5:0] fixed_fn  [6];
  logic [1:0] fixed_op  [3];
  logic [3:0] fixed_exp [3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fixed_fn  = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001010, 6'b001111};
    fixed_op  = '{2'b00, 2'b01, 2'b11};
    fixed_exp = '{4'b0010, 4'b0110, 4'b0110};

    rst_n_i       = 1'b1;
    valid_i       = 1'b0;
    alu_op_i      = '0;
    funct_field_i = '0;

    // Reset with no clock edge in between
    #1;
    rst_n_i       = 1'b0;
    valid_i       = 1'b1;
    alu_op_i      = 2'b10;
    funct_field_i = 6'b001111;
    #2;
    chk("rst_async", {valid_o, illegal_o, operation_o}, 6'b0_0_0010);

    // Reset held across edges with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      valid_i       = 1'($urandom);
      alu_op_i      = 2'($urandom);
      funct_field_i = 6'($urandom);
      @(posedge clk_i);
      #1;
      chk("rst_hold", {valid_o, illegal_o, operation_o}, 6'b0_0_0010);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_n_i = 1'b1;

    for (int c = 0; c < 3; c++)
      for (int f = 0; f < 6; f++)
        apply($sformatf("fixed_op%b_fn%b", fixed_op[c], fixed_fn[f]),
              fixed_op[c], fixed_fn[f], fixed_exp[c], 1'b0);

    apply("r_add", 2'b10, 6'b000000, 4'b0010, 1'b0);
    apply("r_sub", 2'b10, 6'b000010, 4'b0110, 1'b0);
    apply("r_and", 2'b10, 6'b000100, 4'b0000, 1'b0);
    apply("r_or",  2'b10, 6'b000101, 4'b0001, 1'b0);
    apply("r_slt", 2'b10, 6'b001010, 4'b0111, 1'b0);
    apply("r_nor", 2'b10, 6'b000111, 4'b1100, 1'b0);

    apply("hi_add", 2'b10, 6'b100000, 4'b0010, 1'b0);
    apply("hi_slt", 2'b10, 6'b101010, 4'b0111, 1'b0);

    apply("ill_0f",  2'b10, 6'b001111, 4'b1111, 1'b1);
    apply("ill_rec", 2'b10, 6'b000100, 4'b0000, 1'b0);
    apply("ill_01",  2'b10, 6'b000001, 4'b1111, 1'b1);
    apply("ill_3f",  2'b10, 6'b111111, 4'b1111, 1'b1);

    // Hold: valid_i low keeps the illegal result, valid_o drops
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      valid_i       = 1'b0;
      alu_op_i      = 2'b00;
      funct_field_i = 6'b000010;
      @(posedge clk_i);
      #1;
      chk("hold", {valid_o, illegal_o, operation_o}, 6'b0_1_1111);
    end

    apply("pre_rst", 2'b10, 6'b000111, 4'b1100, 1'b1 ^ 1'b1);
    // Mid-stream asynchronous reset, checked before the next edge
    @(negedge clk_i);
    valid_i       = 1'b1;
    alu_op_i      = 2'b10;
    funct_field_i = 6'b001011;
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid", {valid_o, illegal_o, operation_o}, 6'b0_0_0010);
    @(posedge clk_i);
    #1;
    chk("rst_mid_hold", {valid_o, illegal_o, operation_o}, 6'b0_0_0010);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    valid_i = 1'b0;

    apply("post_rst_or", 2'b10, 6'b000101, 4'b0001, 1'b0);
    apply("post_rst_beq", 2'b01, 6'b000000, 4'b0110, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
